// File: rtl/npc_trap_ctrl.sv
// Machine-mode trap sequencer for ecall/mret: updates trap CSRs, stalls the front end,
// issues a PC redirect over a valid/ready handshake and emits one-cycle event pulses.
module npc_trap_ctrl #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     ECALL_CAUSE = 11,
   parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_valid,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            ecall_evt,
   output logic            mret_evt
);

   localparam logic [31:0]     INST_ECALL = 32'h0000_0073;
   localparam logic [31:0]     INST_MRET  = 32'h3020_0073;
   localparam logic [11:0]     ADDR_MSTATUS = 12'h300;
   localparam logic [11:0]     ADDR_MTVEC   = 12'h305;
   localparam logic [11:0]     ADDR_MEPC    = 12'h341;
   localparam logic [11:0]     ADDR_MCAUSE  = 12'h342;
   localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);

   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, REDIR} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_lat_q, pc_lat_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] target_q, target_d;
   logic            mie_q, mie_d;
   logic            mpie_q, mpie_d;
   logic            ecall_evt_q, ecall_evt_d;
   logic            mret_evt_q, mret_evt_d;

   logic            is_ecall;
   logic            is_mret;

   assign is_ecall = inst_valid && (inst == INST_ECALL);
   assign is_mret  = inst_valid && (inst == INST_MRET);

   assign stall          = (state_q != IDLE) || is_ecall || is_mret;
   assign redirect_valid = (state_q == REDIR);
   assign redirect_pc    = target_q;
   assign ecall_evt      = ecall_evt_q;
   assign mret_evt       = mret_evt_q;

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         ADDR_MSTATUS: begin
            csr_rdata[3]     = mie_q;
            csr_rdata[7]     = mpie_q;
            csr_rdata[12:11] = 2'b11;
         end
         ADDR_MTVEC:  csr_rdata = mtvec_q;
         ADDR_MEPC:   csr_rdata = mepc_q;
         ADDR_MCAUSE: csr_rdata = mcause_q;
         default:     csr_rdata = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_lat_d    = pc_lat_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
      mtvec_d     = mtvec_q;
      target_d    = target_q;
      mie_d       = mie_q;
      mpie_d      = mpie_q;
      ecall_evt_d = 1'b0;
      mret_evt_d  = 1'b0;

      // CSR writes only land in IDLE, so SAVE/RESTORE in the following cycle
      // already see a csrrw that retired alongside the ecall/mret.
      if (csr_we && (state_q == IDLE)) begin
         case (csr_waddr)
            ADDR_MSTATUS: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            ADDR_MTVEC:  mtvec_d  = csr_wdata & ALIGN_MASK;
            ADDR_MEPC:   mepc_d   = csr_wdata & ALIGN_MASK;
            ADDR_MCAUSE: mcause_d = csr_wdata;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (is_ecall) begin
               state_d     = SAVE;
               pc_lat_d    = pc;
               ecall_evt_d = 1'b1;
            end else if (is_mret) begin
               state_d    = RESTORE;
               pc_lat_d   = pc;
               mret_evt_d = 1'b1;
            end
         end
         SAVE: begin
            mepc_d   = pc_lat_q & ALIGN_MASK;
            mcause_d = XLEN'(ECALL_CAUSE);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            target_d = mtvec_q & ALIGN_MASK;
            state_d  = REDIR;
         end
         RESTORE: begin
            mie_d    = mpie_q;
            mpie_d   = 1'b1;
            target_d = mepc_q;
            state_d  = REDIR;
         end
         REDIR: begin
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_lat_q    <= '0;
         mepc_q      <= '0;
         mcause_q    <= '0;
         mtvec_q     <= RESET_MTVEC;
         target_q    <= '0;
         mie_q       <= 1'b0;
         mpie_q      <= 1'b0;
         ecall_evt_q <= 1'b0;
         mret_evt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_lat_q    <= pc_lat_d;
         mepc_q      <= mepc_d;
         mcause_q    <= mcause_d;
         mtvec_q     <= mtvec_d;
         target_q    <= target_d;
         mie_q       <= mie_d;
         mpie_q      <= mpie_d;
         ecall_evt_q <= ecall_evt_d;
         mret_evt_q  <= mret_evt_d;
      end
   end

endmodule

// File: tb/tb_npc_trap_ctrl.sv
// Directed self-checking bench for npc_trap_ctrl: ecall/mret sequencing, handshake stall,
// CSR interaction and asynchronous reset.
module tb_npc_trap_ctrl;

   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [31:0] MRET  = 32'h3020_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        ecall_evt;
   logic        mret_evt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   npc_trap_ctrl #(
      .XLEN(32),
      .ECALL_CAUSE(11),
      .RESET_MTVEC(32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .inst_valid(inst_valid),
      .inst(inst),
      .pc(pc),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready),
      .csr_we(csr_we),
      .csr_waddr(csr_waddr),
      .csr_wdata(csr_wdata),
      .csr_raddr(csr_raddr),
      .csr_rdata(csr_rdata),
      .ecall_evt(ecall_evt),
      .mret_evt(mret_evt)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      csr_raddr = a;
      #1;
      d = csr_rdata;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_waddr = a;
      csr_wdata = d;
      tick();
      csr_we = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1; inst_valid = 1'b0; inst = '0; pc = '0; redirect_ready = 1'b0;
      csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0; csr_raddr = '0;
      #12;
      checks++;
      if ({stall, redirect_valid, redirect_pc, ecall_evt, mret_evt} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: got stall=%b rv=%b rpc=%h ee=%b me=%b required all 0",
                  stall, redirect_valid, redirect_pc, ecall_evt, mret_evt);
      end
      @(negedge clk); rst = 1'b0;
      tick();
      rd(12'h300, d); checks++;
      if (d !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %h required 00001800", d); end
      rd(12'h341, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h required 0", d); end
      rd(12'h305, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_mtvec: got %h required 0", d); end
   endtask

   task automatic test_csr();
      logic [31:0] d;
      csr_write(12'h341, 32'h8000_0107);
      rd(12'h341, d); checks++;
      if (d !== 32'h8000_0104) begin errors++; $display("FAIL csr_mepc_align: got %h required 80000104", d); end
      csr_write(12'h342, 32'h0000_0005);
      csr_write(12'h340, 32'hFFFF_FFFF);
      rd(12'h340, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL csr_unmapped_read: got %h required 0", d); end
      rd(12'h342, d); checks++;
      if (d !== 32'h5) begin errors++; $display("FAIL csr_mcause: got %h required 00000005", d); end
      csr_write(12'h300, 32'hFFFF_FFFF);
      rd(12'h300, d); checks++;
      if (d !== 32'h0000_1888) begin errors++; $display("FAIL csr_mstatus_mask: got %h required 00001888", d); end
   endtask

   task automatic test_ecall();
      logic [31:0] d;
      csr_write(12'h305, 32'h8000_0400);
      csr_write(12'h300, 32'h0000_0008);
      redirect_ready = 1'b1;
      inst_valid = 1'b1; inst = ECALL; pc = 32'h8000_0104;
      @(negedge clk); checks++;
      if (stall !== 1'b1 || redirect_valid !== 1'b0 || ecall_evt !== 1'b0) begin
         errors++; $display("FAIL ecall_N: got stall=%b rv=%b ee=%b required 1 0 0", stall, redirect_valid, ecall_evt);
      end
      tick(); inst_valid = 1'b0; pc = 32'hDEAD_BEEF;
      @(negedge clk); checks++;
      if (stall !== 1'b1 || redirect_valid !== 1'b0 || ecall_evt !== 1'b1 || mret_evt !== 1'b0) begin
         errors++; $display("FAIL ecall_N1: got stall=%b rv=%b ee=%b me=%b required 1 0 1 0",
                            stall, redirect_valid, ecall_evt, mret_evt);
      end
      tick();
      @(negedge clk); checks++;
      if (stall !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0400 || ecall_evt !== 1'b0) begin
         errors++; $display("FAIL ecall_N2: got stall=%b rv=%b rpc=%h ee=%b required 1 1 80000400 0",
                            stall, redirect_valid, redirect_pc, ecall_evt);
      end
      tick();
      @(negedge clk); checks++;
      if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
         errors++; $display("FAIL ecall_N3: got stall=%b rv=%b required 0 0", stall, redirect_valid);
      end
      rd(12'h341, d); checks++;
      if (d !== 32'h8000_0104) begin errors++; $display("FAIL ecall_mepc: got %h required 80000104", d); end
      rd(12'h342, d); checks++;
      if (d !== 32'd11) begin errors++; $display("FAIL ecall_mcause: got %h required 0000000b", d); end
      rd(12'h300, d); checks++;
      if (d !== 32'h0000_1880) begin errors++; $display("FAIL ecall_mstatus: got %h required 00001880", d); end
      tick();
   endtask

   task automatic test_mret();
      logic [31:0] d;
      csr_write(12'h341, 32'h8000_0108);
      csr_write(12'h300, 32'h0000_0080);
      redirect_ready = 1'b1;
      inst_valid = 1'b1; inst = MRET; pc = 32'h8000_0500;
      @(negedge clk); checks++;
      if (stall !== 1'b1 || mret_evt !== 1'b0) begin
         errors++; $display("FAIL mret_N: got stall=%b me=%b required 1 0", stall, mret_evt);
      end
      tick(); inst_valid = 1'b0;
      @(negedge clk); checks++;
      if (mret_evt !== 1'b1 || ecall_evt !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("FAIL mret_N1: got me=%b ee=%b stall=%b required 1 0 1", mret_evt, ecall_evt, stall);
      end
      tick();
      @(negedge clk); checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0108 || mret_evt !== 1'b0) begin
         errors++; $display("FAIL mret_N2: got rv=%b rpc=%h me=%b required 1 80000108 0",
                            redirect_valid, redirect_pc, mret_evt);
      end
      tick();
      rd(12'h300, d); checks++;
      if (d !== 32'h0000_1888 || stall !== 1'b0) begin
         errors++; $display("FAIL mret_mstatus: got %h stall=%b required 00001888 0", d, stall);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      redirect_ready = 1'b0;
      inst_valid = 1'b1; inst = ECALL; pc = 32'h8000_0200;
      tick(); inst_valid = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) redirect_ready = 1'b1;
         @(negedge clk); checks++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0400 || stall !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d]: got rv=%b rpc=%h stall=%b required 1 80000400 1",
                               i, redirect_valid, redirect_pc, stall);
         end
         tick();
      end
      @(negedge clk); checks++;
      if (redirect_valid !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL bp_release: got rv=%b stall=%b required 0 0", redirect_valid, stall);
      end
      rd(12'h341, d); checks++;
      if (d !== 32'h8000_0200) begin errors++; $display("FAIL bp_mepc: got %h required 80000200", d); end
      tick();
   endtask

   task automatic test_csr_collision();
      logic [31:0] d;
      csr_write(12'h305, 32'h8000_1000);
      redirect_ready = 1'b0;
      csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'h8000_0403;
      inst_valid = 1'b1; inst = ECALL; pc = 32'h8000_0300;
      tick(); csr_we = 1'b0; inst_valid = 1'b0;
      rd(12'h305, d); checks++;
      if (d !== 32'h8000_0400) begin errors++; $display("FAIL coll_mtvec: got %h required 80000400", d); end
      tick();
      csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h1234_5678;
      @(negedge clk); checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0400) begin
         errors++; $display("FAIL coll_redirect: got rv=%b rpc=%h required 1 80000400", redirect_valid, redirect_pc);
      end
      tick();
      csr_we = 1'b0; redirect_ready = 1'b1;
      tick();
      rd(12'h341, d); checks++;
      if (d !== 32'h8000_0300) begin errors++; $display("FAIL coll_mepc_ignored: got %h required 80000300", d); end
      tick();
   endtask

   task automatic test_reset_in_redir();
      logic [31:0] d;
      redirect_ready = 1'b0;
      inst_valid = 1'b1; inst = ECALL; pc = 32'h8000_0700;
      tick(); inst_valid = 1'b0;
      tick();
      @(negedge clk); checks++;
      if (redirect_valid !== 1'b1) begin
         errors++; $display("FAIL rst_pre: got rv=%b required 1", redirect_valid);
      end
      rst = 1'b1;
      #1; checks++;
      if (redirect_valid !== 1'b0 || stall !== 1'b0 || redirect_pc !== 32'h0) begin
         errors++; $display("FAIL rst_async: got rv=%b stall=%b rpc=%h required 0 0 0",
                            redirect_valid, stall, redirect_pc);
      end
      rd(12'h341, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_mepc: got %h required 0", d); end
      rst = 1'b0;
      tick();
      csr_write(12'h305, 32'h8000_0800);
      redirect_ready = 1'b1;
      inst_valid = 1'b1; inst = ECALL; pc = 32'h8000_0010;
      tick(); inst_valid = 1'b0;
      @(negedge clk); checks++;
      if (ecall_evt !== 1'b1) begin errors++; $display("FAIL rst_new_evt: got %b required 1", ecall_evt); end
      tick();
      @(negedge clk); checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0800) begin
         errors++; $display("FAIL rst_new_redirect: got rv=%b rpc=%h required 1 80000800", redirect_valid, redirect_pc);
      end
      tick();
      rd(12'h341, d); checks++;
      if (d !== 32'h8000_0010) begin errors++; $display("FAIL rst_new_mepc: got %h required 80000010", d); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int unsigned pulses;
      pulses = 0;
      redirect_ready = 1'b1;
      inst_valid = 1'b1; inst = ECALL; pc = 32'h8000_0500;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) pc = 32'h8000_0600;
         if (i == 3) inst_valid = 1'b0;
         @(negedge clk);
         if (ecall_evt === 1'b1) pulses++;
         if (i == 3) begin
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_drop: got %b required 0", stall); end
         end
         tick();
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL b2b_pulses: got %0d required 1", pulses); end
      rd(12'h341, d); checks++;
      if (d !== 32'h8000_0500) begin errors++; $display("FAIL b2b_mepc: got %h required 80000500", d); end
   endtask

   initial begin
      test_reset();
      test_csr();
      test_ecall();
      test_mret();
      test_backpressure();
      test_csr_collision();
      test_reset_in_redir();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
